// File: rtl/rr_switch_arbiter_4port_pkg.sv
// rtl/rr_switch_arbiter_4port_pkg.sv - shared port codes and index constants for the 4-port switch allocator
package rr_switch_arbiter_4port_pkg;

    localparam logic [2:0] SW_STOP  = 3'b000;
    localparam logic [2:0] SW_X1    = 3'b001;
    localparam logic [2:0] SW_X2    = 3'b010;
    localparam logic [2:0] SW_Y1    = 3'b011;
    localparam logic [2:0] SW_LOCAL = 3'b100;

    localparam int P_X1    = 0;
    localparam int P_X2    = 1;
    localparam int P_Y     = 2;
    localparam int P_LOCAL = 3;
    localparam int N_PORTS = 4;

    function automatic logic port_legal(input logic [2:0] code);
        return (code >= SW_X1) && (code <= SW_LOCAL);
    endfunction

    // Port index i is encoded as i+1 on the select bus; 0 is reserved for SW_STOP.
    function automatic logic [2:0] port_code(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/rr_switch_arbiter_4port_rr_arbiter_4.sv
// rtl/rr_switch_arbiter_4port_rr_arbiter_4.sv - 4-way round-robin arbiter with registered rotating pointer
module rr_arbiter_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        if (en) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    ptr_d    = idx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_switch_arbiter_4port.sv
// rtl/rr_switch_arbiter_4port.sv - per-output round-robin switch allocator for the 4-port mesh router
module rr_switch_arbiter_4port
    import rr_switch_arbiter_4port_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [3:0]           req_valid,
    input  logic [2:0]           req_port_x1,
    input  logic [2:0]           req_port_x2,
    input  logic [2:0]           req_port_y,
    input  logic [2:0]           req_port_local,
    input  logic [3:0]           full_in,
    output logic [2:0]           out_sel_x1,
    output logic [2:0]           out_sel_x2,
    output logic [2:0]           out_sel_y,
    output logic [2:0]           out_sel_local,
    output logic [3:0]           out_valid,
    output logic [3:0]           in_adv,
    output logic [CNT_WIDTH-1:0] denied_cnt,
    output logic                 err_sticky
);

    logic [2:0]           req_port [N_PORTS];
    logic [3:0]           legal;
    logic [3:0]           cand     [N_PORTS];
    logic [3:0]           gnt      [N_PORTS];
    logic [3:0]           granted;
    logic                 denied;
    logic                 illegal_any;

    logic [2:0]           sel_q    [N_PORTS];
    logic [2:0]           sel_d    [N_PORTS];
    logic [3:0]           valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    assign req_port[P_X1]    = req_port_x1;
    assign req_port[P_X2]    = req_port_x2;
    assign req_port[P_Y]     = req_port_y;
    assign req_port[P_LOCAL] = req_port_local;

    always_comb begin
        legal       = '0;
        illegal_any = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            legal[i]    = req_valid[i] && port_legal(req_port[i]);
            illegal_any = illegal_any || (req_valid[i] && !port_legal(req_port[i]));
        end
        for (int o = 0; o < N_PORTS; o++) begin
            cand[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                cand[o][i] = legal[i] && (req_port[i] == port_code(2'(o)));
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
        rr_arbiter_4 u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en && !full_in[o]),
            .req   (cand[o]),
            .gnt   (gnt[o])
        );
    end

    // Each input targets a single output, so OR-ing the per-output grants is conflict free.
    always_comb begin
        granted = gnt[0] | gnt[1] | gnt[2] | gnt[3];
        denied  = |(legal & ~granted);
        in_adv  = en ? (~legal | granted) : 4'b0000;
    end

    always_comb begin
        valid_d = valid_q;
        for (int o = 0; o < N_PORTS; o++) begin
            sel_d[o] = sel_q[o];
            if (en && !full_in[o]) begin
                valid_d[o] = |gnt[o];
                sel_d[o]   = SW_STOP;
                for (int i = 0; i < N_PORTS; i++) begin
                    if (gnt[o][i]) begin
                        sel_d[o] = port_code(2'(i));
                    end
                end
            end
        end
        cnt_d = cnt_q;
        if (en && denied && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        err_d = err_q || (en && illegal_any);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < N_PORTS; o++) begin
                sel_q[o] <= SW_STOP;
            end
            valid_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                sel_q[o] <= sel_d[o];
            end
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign out_sel_x1    = sel_q[P_X1];
    assign out_sel_x2    = sel_q[P_X2];
    assign out_sel_y     = sel_q[P_Y];
    assign out_sel_local = sel_q[P_LOCAL];
    assign out_valid     = valid_q;
    assign denied_cnt    = cnt_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_rr_switch_arbiter_4port.sv
// tb/tb_rr_switch_arbiter_4port.sv - self-checking bench for rr_switch_arbiter_4port
module tb_rr_switch_arbiter_4port;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [3:0]    req_valid;
    logic [2:0]    port_in [4];
    logic [3:0]    full_in;
    logic [2:0]    out_sel_x1, out_sel_x2, out_sel_y, out_sel_local;
    logic [3:0]    out_valid;
    logic [3:0]    in_adv;
    logic [CW-1:0] denied_cnt;
    logic          err_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_switch_arbiter_4port #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .req_valid      (req_valid),
        .req_port_x1    (port_in[0]),
        .req_port_x2    (port_in[1]),
        .req_port_y     (port_in[2]),
        .req_port_local (port_in[3]),
        .full_in        (full_in),
        .out_sel_x1     (out_sel_x1),
        .out_sel_x2     (out_sel_x2),
        .out_sel_y      (out_sel_y),
        .out_sel_local  (out_sel_local),
        .out_valid      (out_valid),
        .in_adv         (in_adv),
        .denied_cnt     (denied_cnt),
        .err_sticky     (err_sticky)
    );

    // Reference state: selects per output, valid bits, rotation pointers, counter, error flag.
    int         m_ptr [4];
    logic [2:0] m_sel [4];
    logic [3:0] m_valid;
    int         m_cnt;
    logic       m_err;

    typedef struct {
        logic        en;
        logic [3:0]  rv;
        logic [11:0] ports;    // {local, y, x2, x1}
        logic [3:0]  full;
        logic [3:0]  exp_adv;
        logic [11:0] exp_sel;  // {local, y, x2, x1} after the edge
        logic [3:0]  exp_valid;
        logic [3:0]  exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int i);
        return req_valid[i] && port_in[i] >= 3'd1 && port_in[i] <= 3'd4;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            m_ptr[o] = 0;
            m_sel[o] = 3'd0;
        end
        m_valid = '0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    // Winner per output: first requester for that output found walking up from the pointer, wrapping.
    task automatic model_eval(output logic [3:0] adv, output int win [4]);
        bit got [4];
        for (int i = 0; i < 4; i++) got[i] = 0;
        for (int o = 0; o < 4; o++) begin
            win[o] = -1;
            if (en && !full_in[o]) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % 4;
                    if (win[o] < 0 && legal(i) && int'(port_in[i]) == o + 1) win[o] = i;
                end
            end
            if (win[o] >= 0) got[win[o]] = 1;
        end
        for (int i = 0; i < 4; i++) adv[i] = en && (!legal(i) || got[i]);
    endtask

    task automatic model_commit(input int win [4]);
        bit any_denied = 0;
        bit any_bad    = 0;
        if (!en) return;
        for (int i = 0; i < 4; i++) begin
            bit won = 0;
            for (int o = 0; o < 4; o++) if (win[o] == i) won = 1;
            if (legal(i) && !won) any_denied = 1;
            if (req_valid[i] && !legal(i)) any_bad = 1;
        end
        for (int o = 0; o < 4; o++) begin
            if (!full_in[o]) begin
                if (win[o] >= 0) begin
                    m_sel[o]   = 3'(win[o] + 1);
                    m_valid[o] = 1'b1;
                    m_ptr[o]   = (win[o] + 1) % 4;
                end else begin
                    m_sel[o]   = 3'd0;
                    m_valid[o] = 1'b0;
                end
            end
        end
        if (any_denied && m_cnt < (1 << CW) - 1) m_cnt++;
        if (any_bad) m_err = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " sel_x1"},    32'(out_sel_x1),    32'(m_sel[0]));
        check({tag, " sel_x2"},    32'(out_sel_x2),    32'(m_sel[1]));
        check({tag, " sel_y"},     32'(out_sel_y),     32'(m_sel[2]));
        check({tag, " sel_local"}, 32'(out_sel_local), 32'(m_sel[3]));
        check({tag, " valid"},     32'(out_valid),     32'(m_valid));
        check({tag, " cnt"},       32'(denied_cnt),    32'(m_cnt));
        check({tag, " err"},       32'(err_sticky),    32'(m_err));
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic run_cycle(input string tag);
        logic [3:0] adv;
        int         win [4];
        #1;
        model_eval(adv, win);
        check({tag, " model in_adv"}, 32'(in_adv), 32'(adv));
        @(posedge clk);
        model_commit(win);
        #1;
        check_regs({tag, " model"});
        @(negedge clk);
    endtask

    task automatic apply(input logic e, input logic [3:0] rv, input logic [11:0] p, input logic [3:0] f);
        en        = e;
        req_valid = rv;
        full_in   = f;
        for (int i = 0; i < 4; i++) port_in[i] = p[3*i +: 3];
    endtask

    localparam logic [11:0] P_CONTEND = {3'b011, 3'b000, 3'b000, 3'b011};

    initial begin
        vecs[0]  = '{1'b1, 4'b1001, P_CONTEND, 4'b0000, 4'b0111, {3'b000, 3'b001, 3'b000, 3'b000}, 4'b0100, 4'd1, 1'b0};
        vecs[1]  = '{1'b1, 4'b1001, P_CONTEND, 4'b0000, 4'b1110, {3'b000, 3'b100, 3'b000, 3'b000}, 4'b0100, 4'd2, 1'b0};
        vecs[2]  = '{1'b1, 4'b1001, P_CONTEND, 4'b0000, 4'b0111, {3'b000, 3'b001, 3'b000, 3'b000}, 4'b0100, 4'd3, 1'b0};
        vecs[3]  = '{1'b1, 4'b1001, P_CONTEND, 4'b0000, 4'b1110, {3'b000, 3'b100, 3'b000, 3'b000}, 4'b0100, 4'd4, 1'b0};
        vecs[4]  = '{1'b1, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b010}, 4'b0000, 4'b1111, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b0010, 4'd4, 1'b0};
        vecs[5]  = '{1'b1, 4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 4'b0010, 4'b1011, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b0010, 4'd5, 1'b0};
        vecs[6]  = '{1'b1, 4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 4'b0010, 4'b1011, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b0010, 4'd6, 1'b0};
        vecs[7]  = '{1'b1, 4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 4'b0010, 4'b1011, {3'b000, 3'b000, 3'b001, 3'b000}, 4'b0010, 4'd7, 1'b0};
        vecs[8]  = '{1'b1, 4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 4'b0000, 4'b1111, {3'b000, 3'b000, 3'b011, 3'b000}, 4'b0010, 4'd7, 1'b0};
        vecs[9]  = '{1'b1, 4'b1111, {3'b011, 3'b010, 3'b001, 3'b100}, 4'b0000, 4'b1111, {3'b001, 3'b100, 3'b011, 3'b010}, 4'b1111, 4'd7, 1'b0};
        vecs[10] = '{1'b1, 4'b0010, {3'b000, 3'b000, 3'b110, 3'b000}, 4'b0000, 4'b1111, 12'h000, 4'b0000, 4'd7, 1'b1};
        vecs[11] = '{1'b0, 4'b1001, P_CONTEND, 4'b0000, 4'b0000, 12'h000, 4'b0000, 4'd7, 1'b1};

        rst_n = 1'b0;
        apply(1'b1, 4'b0000, 12'h000, 4'b0000);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_adv", 32'(in_adv), 32'hF);
        check_regs("reset");
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            apply(vecs[v].en, vecs[v].rv, vecs[v].ports, vecs[v].full);
            #1;
            check($sformatf("vec%0d in_adv", v), 32'(in_adv), 32'(vecs[v].exp_adv));
            run_cycle($sformatf("vec%0d", v));
            check($sformatf("vec%0d sel", v), 32'({out_sel_local, out_sel_y, out_sel_x2, out_sel_x1}), 32'(vecs[v].exp_sel));
            check($sformatf("vec%0d valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d cnt", v), 32'(denied_cnt), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d err", v), 32'(err_sticky), 32'(vecs[v].exp_err));
        end

        // Saturation: 21 more contended cycles from 7 leaves the Y pointer at 1.
        apply(1'b1, 4'b1001, P_CONTEND, 4'b0000);
        for (int c = 0; c < 21; c++) run_cycle("sat");
        check("sat cnt", 32'(denied_cnt), 32'hF);
        check("sat err held", 32'(err_sticky), 32'd1);

        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async cnt", 32'(denied_cnt), 32'd0);
        check("async sel_y", 32'(out_sel_y), 32'd0);
        check("async valid", 32'(out_valid), 32'd0);
        check("async err", 32'(err_sticky), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle("post reset");
        check("ptr reset sel_y", 32'(out_sel_y), 32'(3'b001));

        for (int c = 0; c < 400; c++) begin
            logic [11:0] p;
            p = 12'($urandom);
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) != 0) p[3*i +: 3] = 3'($urandom_range(1, 4));
            apply($urandom_range(0, 9) != 0, 4'($urandom), p, 4'($urandom) & 4'($urandom));
            run_cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
